// File: rtl/layer_sequencer.sv
// Control sequencer for a layered matrix-vector engine: loads each row, runs its
// compute beats, waits out the rounding latency, then drains one result per row.
module layer_sequencer #(
    parameter int N_LAYER = 4,
    parameter int N_ROW   = 16,
    parameter int N_BEAT  = 8,
    localparam int LW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1,
    localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1,
    localparam int BW = (N_BEAT > 1) ? $clog2(N_BEAT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          data_rdy_i,
    output logic          read_en_o,
    output logic [1:0]    wire_connect_o,
    output logic          acc_clr_o,
    output logic [LW-1:0] layer_o,
    output logic [RW-1:0] row_o,
    output logic          out_vld_o,
    input  logic          out_rdy_i,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_ROUND   = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [LW-1:0] LAST_LAYER = LW'(N_LAYER - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(N_ROW - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(N_BEAT - 1);

    state_t        state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          round_q, round_d;
    logic [RW-1:0] drain_q, drain_d;
    logic          first_layer;

    assign first_layer = (layer_q == '0);
    assign layer_o     = layer_q;
    assign row_o       = row_q;

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        row_d          = row_q;
        beat_d         = beat_q;
        round_d        = round_q;
        drain_d        = drain_q;
        read_en_o      = 1'b0;
        wire_connect_o = 2'd3;
        acc_clr_o      = 1'b0;
        out_vld_o      = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    layer_d = '0;
                    row_d   = '0;
                    beat_d  = '0;
                    round_d = 1'b0;
                    drain_d = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                acc_clr_o = 1'b1;
                if (first_layer) begin
                    wire_connect_o = 2'd0;
                    if (data_rdy_i) begin
                        read_en_o = 1'b1;
                        state_d   = S_COMPUTE;
                    end
                end else begin
                    wire_connect_o = 2'd1;
                    state_d        = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // Layer 0 streams from upstream and stalls on it; later layers run free on feedback.
                wire_connect_o = first_layer ? 2'd0 : 2'd2;
                read_en_o      = first_layer && data_rdy_i;
                if (!first_layer || data_rdy_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        round_d = 1'b0;
                        state_d = S_ROUND;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_ROUND: begin
                if (!round_q) begin
                    round_d = 1'b1;
                end else begin
                    round_d = 1'b0;
                    if (row_q != LAST_ROW) begin
                        row_d   = row_q + RW'(1);
                        state_d = S_LOAD;
                    end else if (layer_q != LAST_LAYER) begin
                        row_d   = '0;
                        layer_d = layer_q + LW'(1);
                        state_d = S_LOAD;
                    end else begin
                        drain_d = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                out_vld_o = 1'b1;
                if (out_rdy_i) begin
                    if (drain_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + RW'(1);
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            row_q   <= '0;
            beat_q  <= '0;
            round_q <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            round_q <= round_d;
            drain_q <= drain_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench: instance 0 is the 2x2x4 configuration, instance 1 the 1x1x2 minimum.
module tb_layer_sequencer;

    logic       clk;
    logic       rstn_a     [2];
    logic       start_a    [2];
    logic       data_rdy_a [2];
    logic       read_en_a  [2];
    logic [1:0] wire_a     [2];
    logic       acc_clr_a  [2];
    logic       layer_a    [2];
    logic       row_a      [2];
    logic       vld_a      [2];
    logic       out_rdy_a  [2];
    logic       busy_a     [2];
    logic       done_a     [2];

    layer_sequencer #(.N_LAYER(2), .N_ROW(2), .N_BEAT(4)) dut0 (
        .clk(clk), .rst_n(rstn_a[0]), .start_i(start_a[0]), .data_rdy_i(data_rdy_a[0]),
        .read_en_o(read_en_a[0]), .wire_connect_o(wire_a[0]), .acc_clr_o(acc_clr_a[0]),
        .layer_o(layer_a[0]), .row_o(row_a[0]), .out_vld_o(vld_a[0]),
        .out_rdy_i(out_rdy_a[0]), .busy_o(busy_a[0]), .done_o(done_a[0])
    );

    layer_sequencer #(.N_LAYER(1), .N_ROW(1), .N_BEAT(2)) dut1 (
        .clk(clk), .rst_n(rstn_a[1]), .start_i(start_a[1]), .data_rdy_i(data_rdy_a[1]),
        .read_en_o(read_en_a[1]), .wire_connect_o(wire_a[1]), .acc_clr_o(acc_clr_a[1]),
        .layer_o(layer_a[1]), .row_o(row_a[1]), .out_vld_o(vld_a[1]),
        .out_rdy_i(out_rdy_a[1]), .busy_o(busy_a[1]), .done_o(done_a[1])
    );

    typedef struct {
        int start_cyc;
        int done_rel;
        int reads;
        int xfers;
        int vld;
        int busy;
        int w1;
        int w2;
        int clr;
        int viol;
        int layer_f;
        int row_f;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int a_reads[2], a_xfer[2], a_vld[2], a_busy[2];
    int a_w1[2], a_w2[2], a_clr[2], a_viol[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic clear_acc(input int k);
        a_reads[k] = 0; a_xfer[k] = 0; a_vld[k] = 0; a_busy[k] = 0;
        a_w1[k] = 0; a_w2[k] = 0; a_clr[k] = 0; a_viol[k] = 0;
    endtask

    // Monitor: accumulates per-run activity and checks it against the queued expectation on done_o.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn_a[k]) begin
                clear_acc(k);
            end else begin
                a_reads[k] += int'(read_en_a[k]);
                a_viol[k]  += int'(read_en_a[k] && !data_rdy_a[k]);
                a_xfer[k]  += int'(vld_a[k] && out_rdy_a[k]);
                a_vld[k]   += int'(vld_a[k]);
                a_busy[k]  += int'(busy_a[k]);
                a_w1[k]    += int'(wire_a[k] == 2'd1);
                a_w2[k]    += int'(wire_a[k] == 2'd2);
                a_clr[k]   += int'(acc_clr_a[k]);
                if (done_a[k]) begin
                    exp_t e;
                    bit   got;
                    got = 1'b0;
                    if (k == 0 && q0.size() > 0) begin
                        e = q0.pop_front(); got = 1'b1;
                    end else if (k == 1 && q1.size() > 0) begin
                        e = q1.pop_front(); got = 1'b1;
                    end
                    chk($sformatf("dut%0d_done_expected", k), int'(got), 1);
                    if (got) begin
                        chk($sformatf("dut%0d_done_cycle", k), cyc - e.start_cyc, e.done_rel);
                        chk($sformatf("dut%0d_read_pulses", k), a_reads[k], e.reads);
                        chk($sformatf("dut%0d_transfers", k), a_xfer[k], e.xfers);
                        chk($sformatf("dut%0d_vld_cycles", k), a_vld[k], e.vld);
                        chk($sformatf("dut%0d_busy_cycles", k), a_busy[k], e.busy);
                        chk($sformatf("dut%0d_wire1_cycles", k), a_w1[k], e.w1);
                        chk($sformatf("dut%0d_wire2_cycles", k), a_w2[k], e.w2);
                        chk($sformatf("dut%0d_accclr_cycles", k), a_clr[k], e.clr);
                        chk($sformatf("dut%0d_read_without_rdy", k), a_viol[k], e.viol);
                        chk($sformatf("dut%0d_final_layer", k), int'(layer_a[k]), e.layer_f);
                        chk($sformatf("dut%0d_final_row", k), int'(row_a[k]), e.row_f);
                        $display("[TB] dut%0d run done at rel cycle %0d reads=%0d xfers=%0d",
                                 k, cyc - e.start_cyc, a_reads[k], a_xfer[k]);
                    end
                    clear_acc(k);
                end
            end
        end
    end

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("%s_busy", tag), int'(busy_a[k]), 0);
        chk($sformatf("%s_read_en", tag), int'(read_en_a[k]), 0);
        chk($sformatf("%s_acc_clr", tag), int'(acc_clr_a[k]), 0);
        chk($sformatf("%s_out_vld", tag), int'(vld_a[k]), 0);
        chk($sformatf("%s_done", tag), int'(done_a[k]), 0);
        chk($sformatf("%s_wire", tag), int'(wire_a[k]), 3);
        chk($sformatf("%s_layer", tag), int'(layer_a[k]), 0);
        chk($sformatf("%s_row", tag), int'(row_a[k]), 0);
    endtask

    // One run on instance 0; rst_at >= 0 aborts the run with a reset at that relative cycle.
    task automatic run0(input string tag, input int stall_len, input int bp_len,
                        input bit extra_starts, input int rst_at);
        exp_t e;
        int   c0;
        int   dlen;
        c0   = cyc;
        dlen = 31 + stall_len + bp_len;
        if (rst_at < 0) begin
            e.start_cyc = c0;   e.done_rel = dlen; e.reads = 10;  e.xfers = 2;
            e.vld = 2 + bp_len; e.busy = dlen;     e.w1 = 2;      e.w2 = 8;
            e.clr = 4;          e.viol = 0;        e.layer_f = 1; e.row_f = 1;
            q0.push_back(e);
        end
        $display("[TB] dut0 %s start at cycle %0d", tag, c0);
        for (int rel = 0; rel <= dlen + 2; rel++) begin
            start_a[0]    = (rel == 0) || (extra_starts && (rel == 5 || rel == 20));
            data_rdy_a[0] = !(rel >= 4 && rel < 4 + stall_len);
            out_rdy_a[0]  = !(rel >= 29 + stall_len && rel < 29 + stall_len + bp_len);
            rstn_a[0]     = (rel != rst_at);
            @(posedge clk); #1;
            if (rel == rst_at) begin
                chk_idle(0, $sformatf("%s_after_reset", tag));
                rstn_a[0] = 1'b1;
                break;
            end
        end
        start_a[0]    = 1'b0;
        data_rdy_a[0] = 1'b1;
        out_rdy_a[0]  = 1'b1;
        if (rst_at < 0) chk($sformatf("%s_run_completed", tag), q0.size(), 0);
        else begin
            repeat (40) begin
                @(posedge clk); #1;
            end
            chk($sformatf("%s_no_resume_busy", tag), int'(busy_a[0]), 0);
        end
    endtask

    task automatic run1(input string tag);
        exp_t e;
        e.start_cyc = cyc; e.done_rel = 7; e.reads = 3;   e.xfers = 1;
        e.vld = 1;         e.busy = 7;     e.w1 = 0;      e.w2 = 0;
        e.clr = 1;         e.viol = 0;     e.layer_f = 0; e.row_f = 0;
        q1.push_back(e);
        $display("[TB] dut1 %s start at cycle %0d", tag, cyc);
        for (int rel = 0; rel <= 9; rel++) begin
            start_a[1] = (rel == 0);
            @(posedge clk); #1;
        end
        start_a[1] = 1'b0;
        chk($sformatf("%s_run_completed", tag), q1.size(), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn_a[k] = 1'b0; start_a[k] = 1'b1; data_rdy_a[k] = 1'b1; out_rdy_a[k] = 1'b1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk_idle(0, "dut0_reset");
        chk_idle(1, "dut1_reset");
        for (int k = 0; k < 2; k++) begin
            rstn_a[k] = 1'b1; start_a[k] = 1'b0;
        end
        @(posedge clk); #1;
        chk_idle(0, "dut0_post_reset");

        run0("nominal", 0, 0, 1'b0, -1);
        run0("input_stall", 3, 0, 1'b0, -1);
        run0("backpressure", 0, 5, 1'b0, -1);
        run0("reset_mid_load", 0, 0, 1'b0, 15);
        run0("after_reset", 0, 0, 1'b0, -1);
        run0("reset_mid_drain", 0, 0, 1'b0, 29);
        run0("start_while_busy", 0, 0, 1'b1, -1);
        run1("minimal");
        run1("minimal_again");

        repeat (5) begin
            @(posedge clk); #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter N_LAYER, default 4: number of layers per run (>=1).
REQ-002 SHALL have parameter N_ROW, default 16: weight rows per layer (>=1).
REQ-003 SHALL have parameter N_BEAT, default 8: compute beats per row (>=2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit: run request; sampled only in IDLE.
REQ-007 SHALL have port data_rdy_i, input, 1 bit: upstream input word available.
REQ-008 SHALL have port read_en_o, output, 1 bit: pop upstream word; never high while data_rdy_i=0.
REQ-009 SHALL have port wire_connect_o, output, 2 bits: datapath mux select; 0=first-layer input, 1=feedback load, 2=feedback compute, 3=disconnected.
REQ-010 SHALL have port acc_clr_o, output, 1 bit: clear PE accumulators.
REQ-011 SHALL have port layer_o, output, clog2(N_LAYER) bits (min 1): current layer index.
REQ-012 SHALL have port row_o, output, clog2(N_ROW) bits (min 1): current row index.
REQ-013 SHALL have port out_vld_o, output, 1 bit: result word valid.
REQ-014 SHALL have port out_rdy_i, input, 1 bit: result sink ready.
REQ-015 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, LOAD, COMPUTE, ROUND, DRAIN and DONE, together with internal counters: layer, row, beat (0..N_BEAT-1), round (0..1) and drain (0..N_ROW-1).
REQ-018 SHALL, in IDLE, output wire_connect_o=3 with all other outputs 0, and on start_i=1 clear all counters and go to LOAD.
REQ-019 SHALL handle LOAD as follows:
- acc_clr_o=1.
- Layer 0: wire_connect_o=0; stay in LOAD while data_rdy_i=0; when data_rdy_i=1, assert read_en_o and go to COMPUTE.
- Layer >0: wire_connect_o=1, read_en_o=0, exactly one cycle, then go to COMPUTE.
REQ-020 SHALL handle COMPUTE as follows:
- Layer 0: wire_connect_o=0, read_en_o=data_rdy_i, and beat advances only when data_rdy_i=1 (stall otherwise; no other output changes).
- Layer >0: wire_connect_o=2, read_en_o=0, and beat advances every cycle.
- On an advance at beat=N_BEAT-1: clear beat and go to ROUND.
REQ-021 SHALL hold ROUND for exactly 2 cycles with wire_connect_o=3 and read_en_o=0, then exit as follows:
- row<N_ROW-1: row+1, go to LOAD.
- row=N_ROW-1 and layer<N_LAYER-1: row=0, layer+1, go to LOAD.
- Otherwise: go to DRAIN.
REQ-022 SHALL, in DRAIN, assert out_vld_o=1 and wire_connect_o=3, and count one transfer per cycle with out_vld_o=1 and out_rdy_i=1; after transfer N_ROW go to DONE.
REQ-023 SHALL hold out_vld_o high in DRAIN until the transfer completes, regardless of out_rdy_i.
REQ-024 SHALL, in DONE, assert done_o=1 for one cycle and then go to IDLE, where start_i is honoured from the next cycle.
REQ-025 SHALL ignore start_i in every state other than IDLE.
REQ-026 SHALL drive layer_o and row_o directly from the counters; they hold their final values in DRAIN and DONE and clear on the next start.
REQ-027 SHALL make all counter comparisons at exact terminal values, with no wrap-around beyond the parameter limits.
REQ-028 SHALL take an unreachable state encoding to IDLE on the next cycle.
REQ-029 SHALL generate all outputs as Moore/registered-state decodes, except read_en_o, which also depends on data_rdy_i.

Reset
REQ-030 SHALL, on rst_n=0 at a clock edge, go to IDLE, clear all counters and set outputs to read_en_o=0, acc_clr_o=0, out_vld_o=0, busy_o=0, done_o=0, wire_connect_o=3, layer_o=0, row_o=0.
REQ-031 SHALL give reset priority over start_i and over any state transition, including mid-COMPUTE and mid-DRAIN, with no residual pulse after reset.

Verification
REQ-032 SHALL pass the nominal run: N_LAYER=2, N_ROW=2, N_BEAT=4, data_rdy_i=1, out_rdy_i=1, start_i at cycle 0 -> LOAD at cycle 1, DRAIN at cycles 29-30, done_o only at cycle 31, busy_o high for cycles 1-31, exactly 10 read_en_o pulses.
REQ-033 SHALL pass the input stall: same configuration, data_rdy_i=0 for 3 cycles during layer-0 COMPUTE beat 2 -> beat frozen, read_en_o=0 during the stall, done_o delayed by exactly 3 cycles.
REQ-034 SHALL pass output backpressure: out_rdy_i=0 for the first 5 DRAIN cycles -> out_vld_o held high throughout, exactly 2 transfers, done_o 5 cycles later than nominal.
REQ-035 SHALL pass reset mid-run: rst_n=0 at cycle 15 -> next cycle in IDLE with all outputs at reset values; a new start completes with nominal timing.
REQ-036 SHALL pass start while busy: start_i pulsed at cycles 5 and 20 -> no effect; exactly one done_o pulse.
REQ-037 SHALL pass the minimal configuration: N_LAYER=1, N_ROW=1, N_BEAT=2 -> LOAD, COMPUTE x2, ROUND x2, DRAIN x1, DONE; 3 read_en_o pulses and wire_connect_o never 1 or 2.
